// File: rtl/ahb_port_ram_slave_param.sv
// AHB-Lite single-port RAM slave: byte-lane writes, fixed wait states, write-to-read forwarding.
// Define AHB_RAM_ERR_WINDOW_EN to return ERROR for beats hitting the ERR_BASE/ERR_MASK window.
module ahb_port_ram_slave_param #(
  parameter int                ADDR_W      = 30,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 4096,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] ERR_BASE    = 'h1000,
  parameter logic [ADDR_W-1:0] ERR_MASK    = 'hFFF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_ahb_0_hmastlock,
  input  logic [1:0]        io_ahb_0_htrans,
  input  logic [2:0]        io_ahb_0_hsize,
  input  logic [2:0]        io_ahb_0_hburst,
  input  logic              io_ahb_0_hwrite,
  input  logic [3:0]        io_ahb_0_hprot,
  input  logic [ADDR_W-1:0] io_ahb_0_haddr,
  input  logic [DATA_W-1:0] io_ahb_0_hwdata,
  output logic              io_ahb_0_hready,
  output logic              io_ahb_0_hresp,
  output logic [DATA_W-1:0] io_ahb_0_hrdata
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [IW-1:0]     dp_idx_q, dp_idx_d;
  logic [NB-1:0]     dp_mask_q, dp_mask_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              hready, accept, size_bad, misalign, win_hit, legal, wr_en;
  logic [LB-1:0]     a_off;
  logic [IW-1:0]     a_idx;
  logic [NB-1:0]     a_mask;
  logic [DATA_W-1:0] wr_merged, rd_word;
  logic              unused_ok;

  assign hready          = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign io_ahb_0_hready = hready;
  assign io_ahb_0_hresp  = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign io_ahb_0_hrdata = hrdata_q;

  assign a_off    = io_ahb_0_haddr[LB-1:0];
  assign a_idx    = io_ahb_0_haddr[LB+IW-1:LB];
  assign accept   = hready & io_ahb_0_htrans[1];
  assign size_bad = io_ahb_0_hsize > 3'(LB);

`ifdef AHB_RAM_ERR_WINDOW_EN
  assign win_hit = (io_ahb_0_haddr & ~ERR_MASK) == ERR_BASE;
`else
  assign win_hit = 1'b0;
`endif

  assign legal = !size_bad && !misalign && !win_hit;

  always_comb begin
    a_mask   = '0;
    misalign = 1'b0;
    for (int j = 0; j < LB; j++)
      if (j < int'(io_ahb_0_hsize) && a_off[j]) misalign = 1'b1;
    for (int i = 0; i < NB; i++)
      if (i >= int'(a_off) && i < int'(a_off) + (1 << io_ahb_0_hsize)) a_mask[i] = 1'b1;
  end

  // Data phase completes whenever we sit in IDLE with a live beat; that is the commit cycle.
  assign wr_en = (state_q == S_IDLE) && dp_valid_q && dp_write_q;

  always_comb begin
    wr_merged = mem[dp_idx_q];
    for (int i = 0; i < NB; i++)
      if (dp_mask_q[i]) wr_merged[8*i +: 8] = io_ahb_0_hwdata[8*i +: 8];
    rd_word = (wr_en && dp_idx_q == a_idx) ? wr_merged : mem[a_idx];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_mask_d  = dp_mask_q;
    hrdata_d   = hrdata_q;
    if (hready) dp_valid_d = accept && legal;
    if (accept) begin
      dp_write_d = io_ahb_0_hwrite;
      dp_idx_d   = a_idx;
      dp_mask_d  = a_mask;
    end
    unique case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept && !legal) begin
          state_d = S_ERR1;
          if (!io_ahb_0_hwrite) hrdata_d = '0;
        end else if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else if (!io_ahb_0_hwrite) begin
            hrdata_d = rd_word;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          // Any earlier write already committed, so RAM is current here.
          if (!dp_write_q) hrdata_d = mem[dp_idx_q];
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_mask_q  <= '0;
      hrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_mask_q  <= dp_mask_d;
      hrdata_q   <= hrdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[dp_idx_q] <= wr_merged;
  end

  assign unused_ok = &{1'b0, io_ahb_0_hmastlock, io_ahb_0_hburst, io_ahb_0_hprot,
                       io_ahb_0_htrans[0], io_ahb_0_haddr, ERR_BASE, ERR_MASK};
endmodule

// File: tb/tb_ahb_port_ram_slave_param.sv
// Bench for ahb_port_ram_slave_param: two instances (0 and 2 wait states) behind a shared
// driver, a byte-level memory model and a per-cycle bus monitor.
module tb_ahb_port_ram_slave_param;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        sel;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [29:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans0, htrans1;
  logic        hready0, hready1, hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;

  always #5 clock = ~clock;

  assign htrans0  = sel ? 2'b00 : htrans;
  assign htrans1  = sel ? htrans : 2'b00;
  assign m_hready = sel ? hready1 : hready0;
  assign m_hresp  = sel ? hresp1 : hresp0;
  assign m_hrdata = sel ? hrdata1 : hrdata0;

  ahb_port_ram_slave_param #(.WAIT_STATES(0)) u0 (
    .clock(clock), .reset_n(reset_n), .io_ahb_0_hmastlock(1'b0), .io_ahb_0_htrans(htrans0),
    .io_ahb_0_hsize(hsize), .io_ahb_0_hburst(3'b000), .io_ahb_0_hwrite(hwrite),
    .io_ahb_0_hprot(4'h3), .io_ahb_0_haddr(haddr), .io_ahb_0_hwdata(hwdata),
    .io_ahb_0_hready(hready0), .io_ahb_0_hresp(hresp0), .io_ahb_0_hrdata(hrdata0));

  ahb_port_ram_slave_param #(.WAIT_STATES(2)) u1 (
    .clock(clock), .reset_n(reset_n), .io_ahb_0_hmastlock(1'b0), .io_ahb_0_htrans(htrans1),
    .io_ahb_0_hsize(hsize), .io_ahb_0_hburst(3'b000), .io_ahb_0_hwrite(hwrite),
    .io_ahb_0_hprot(4'h3), .io_ahb_0_haddr(haddr), .io_ahb_0_hwdata(hwdata),
    .io_ahb_0_hready(hready1), .io_ahb_0_hresp(hresp1), .io_ahb_0_hrdata(hrdata1));

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---- model: byte memory per instance, wrapped over DEPTH*4 bytes ----
  logic [7:0] mb [longint];

  function automatic longint key(logic s, logic [29:0] a);
    return longint'(s) * 65536 + longint'(a % 30'd16384);
  endfunction

  function automatic logic m_err(logic [2:0] sz, logic [29:0] a);
    if (sz > 3'd2) return 1'b1;
    if ((a % (30'd1 << sz)) != 0) return 1'b1;
`ifdef AHB_RAM_ERR_WINDOW_EN
    if ((a & ~30'hFFF) == 30'h1000) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // ---- monitor ----
  logic        dp_act = 1'b0, dp_wr, dp_err;
  logic [2:0]  dp_sz;
  logic [29:0] dp_a;
  int          lows;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_lows;

  always @(negedge clock) begin
    if (!reset_n) dp_act = 1'b0;
    else begin
      if (dp_act) begin
        if (m_hready) begin
          chk("resp", {31'd0, m_hresp}, {31'd0, dp_err});
          chk("waits", lows, dp_err ? 1 : (sel ? 2 : 0));
          last_err  = m_hresp;
          last_lows = lows;
          if (!dp_err) begin
            if (dp_wr) begin
              for (int i = 0; i < 4; i++)
                if (i >= int'(dp_a % 4) && i < int'(dp_a % 4) + (1 << dp_sz))
                  mb[key(sel, (dp_a & ~30'd3) + 30'(i))] = hwdata[8*i +: 8];
            end else begin
              logic [31:0] ex;
              for (int i = 0; i < 4; i++) ex[8*i +: 8] = mb[key(sel, (dp_a & ~30'd3) + 30'(i))];
              chk("rdata", m_hrdata, ex);
              last_rd = m_hrdata;
            end
          end
          dp_act = 1'b0;
        end else begin
          lows++;
          chk("wait_resp", {31'd0, m_hresp}, {31'd0, dp_err});
        end
      end else begin
        chk("idle_ready", {31'd0, m_hready}, 32'd1);
        chk("idle_resp", {31'd0, m_hresp}, 32'd0);
      end
      if (m_hready && htrans[1]) begin
        dp_act = 1'b1;
        dp_wr  = hwrite;
        dp_sz  = hsize;
        dp_a   = haddr;
        dp_err = m_err(hsize, haddr);
        lows   = 0;
      end
    end
  end

  // ---- driver ----
  typedef struct {
    logic        wr;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [29:0] a;
    logic [31:0] d;
  } beat_t;
  beat_t seq[$];

  task automatic push(logic w, logic [1:0] t, logic [2:0] s, logic [29:0] a, logic [31:0] d);
    beat_t b;
    b.wr = w; b.tr = t; b.sz = s; b.a = a; b.d = d;
    seq.push_back(b);
  endtask

  task automatic wait_acc();
    int n = 0;
    @(negedge clock);
    while (!m_hready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: hready stuck low, got %b expected 1", m_hready);
    end
    @(posedge clock);
    #1;
  endtask

  // Pipelined: beat i's address phase overlaps beat i-1's data phase.
  task automatic run_seq();
    for (int i = 0; i <= seq.size(); i++) begin
      if (i < seq.size()) begin
        htrans = seq[i].tr; hwrite = seq[i].wr; hsize = seq[i].sz; haddr = seq[i].a;
      end else begin
        htrans = 2'b00; hwrite = 1'b0;
      end
      if (i > 0) hwdata = seq[i-1].d;
      wait_acc();
    end
    seq.delete();
  endtask

  localparam logic [1:0] NS = 2'b10, BZ = 2'b01;

  initial begin
    reset_n = 1'b0; sel = 1'b0; htrans = 2'b00; hsize = 3'd2; hwrite = 1'b0;
    haddr = '0; hwdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready0", {31'd0, hready0}, 32'd1);
    chk("rst_resp0", {31'd0, hresp0}, 32'd0);
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_ready1", {31'd0, hready1}, 32'd1);
    chk("rst_rdata1", hrdata1, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // basic write then read, zero wait
    push(1, NS, 2, 30'h40, 32'hDEADBEEF); run_seq();
    push(0, NS, 2, 30'h40, 32'h0); run_seq();
    chk("t1_rdata", last_rd, 32'hDEADBEEF);
    chk("t1_lows", last_lows, 0);

    // byte/halfword lane merge, with a BUSY beat in the middle
    push(1, NS, 2, 30'h80, 32'h11223344);
    push(1, NS, 0, 30'h81, 32'h0000AA00);
    push(0, BZ, 2, 30'h84, 32'h0);
    push(1, NS, 1, 30'h82, 32'h55660000);
    push(0, NS, 2, 30'h80, 32'h0);
    run_seq();
    chk("t2_rdata", last_rd, 32'h5566AA44);

    // forwarding: read address phase during write data phase
    push(1, NS, 2, 30'h100, 32'hCAFEF00D);
    push(0, NS, 2, 30'h100, 32'h0);
    run_seq();
    chk("t4_rdata", last_rd, 32'hCAFEF00D);

    // misaligned and oversize errors, then a legal beat accepted in ERR2
    push(0, NS, 1, 30'h01, 32'h0); run_seq();
    chk("t5_err", {31'd0, last_err}, 32'd1);
    chk("t5_lows", last_lows, 1);
    push(0, NS, 3, 30'h48, 32'h0);
    push(0, NS, 2, 30'h40, 32'h0);
    run_seq();
    chk("t5_after_err", last_rd, 32'hDEADBEEF);

    // window: 0x5004 aliases word 0x1004 via index wrap but lies outside the window
    push(1, NS, 2, 30'h5004, 32'h0BADF00D);
    push(1, NS, 2, 30'h1004, 32'h77777777);
    push(0, NS, 2, 30'h1004, 32'h0);
    push(0, NS, 2, 30'h5004, 32'h0);
    run_seq();
`ifdef AHB_RAM_ERR_WINDOW_EN
    chk("t5_window", last_rd, 32'h0BADF00D);
`else
    chk("t5_window", last_rd, 32'h77777777);
`endif

    // two wait states
    sel = 1'b1;
    push(1, NS, 2, 30'h40, 32'h0F0F0F0F);
    push(0, NS, 2, 30'h40, 32'h0);
    run_seq();
    chk("t3_rdata", last_rd, 32'h0F0F0F0F);
    chk("t3_lows", last_lows, 2);
    push(1, NS, 0, 30'h43, 32'hA5000000);
    push(0, NS, 2, 30'h40, 32'h0);
    run_seq();
    chk("t3_merge", last_rd, 32'hA50F0F0F);

    // reset during WAIT of a write: write must be dropped
    push(1, NS, 2, 30'h200, 32'hAAAA5555); run_seq();
    htrans = NS; hwrite = 1'b1; hsize = 3'd2; haddr = 30'h200;
    @(negedge clock);
    @(posedge clock);
    #1;
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h12345678;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_ready", {31'd0, hready1}, 32'd1);
    chk("t6_rst_resp", {31'd0, hresp1}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    push(0, NS, 2, 30'h200, 32'h0); run_seq();
    chk("t6_old", last_rd, 32'hAAAA5555);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
